security_controller: RTL and testbench
======================================

SECURITY_CONTROLLER -- requirements
Module: security_controller

Interface
REQ-001 SHALL provide parameter NZONES, default 4, number of sensor zones (window/door sensor alarm outputs); zone 0 is the entry door.
REQ-002 SHALL provide parameter EXIT_CYC, default 16, exit-delay length in clk cycles.
REQ-003 SHALL provide parameter ENTRY_CYC, default 8, entry-delay length in clk cycles.
REQ-004 SHALL provide parameter CODE, default 4'hA, disarm code.
REQ-005 SHALL provide parameter MAX_FAIL, default 3, wrong codes before lockout.
REQ-006 SHALL provide parameter LOCK_CYC, default 32, lockout length in clk cycles.
REQ-007 SHALL have one clock, clk; reset is synchronous and active-high, port rst.
REQ-008 clk  in  1  rising-edge clock for all state.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 zone_trip  in  NZONES  level per-zone alarm from sensor modules, 1 = tripped.
REQ-011 arm_req  in  1  one-cycle arm request.
REQ-012 code  in  4  keypad code, sampled only when code_vld=1.
REQ-013 code_vld  in  1  one-cycle code-entry strobe.
REQ-014 siren  out  1  registered, 1 in ALARM or LOCKOUT.
REQ-015 armed  out  1  registered, 1 in ARMED or ENTRY.
REQ-016 state  out  3  current state encoding.
REQ-017 trip_zone  out  clog2(NZONES)  latched index of zone causing the trigger.
REQ-018 fail_cnt  out  2  consecutive wrong-code count.

Function
REQ-019 SHALL implement states DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4, LOCKOUT=5; codes 6-7 SHALL return to DISARMED next cycle.
REQ-020 SHALL use one down-counter timer, loaded with N-1 on entering a timed state; the state expires on the cycle timer==0, giving exactly N cycles of residency.
REQ-021 DISARMED: arm_req with zone_trip==0 -> EXIT (load EXIT_CYC-1); arm_req with any zone tripped ignored; code_vld ignored.
REQ-022 EXIT: zone_trip ignored; timer expiry -> ARMED; correct code -> DISARMED.
REQ-023 ARMED: zone_trip==1 (only zone 0) -> ENTRY (load ENTRY_CYC-1); any zone >0 tripped -> ALARM next cycle; trip_zone latches lowest set index.
REQ-024 ENTRY: correct code -> DISARMED; timer expiry -> ALARM; any zone >0 tripped -> ALARM immediately, trip_zone unchanged.
REQ-025 ALARM: correct code -> DISARMED; zone_trip ignored; siren holds until disarmed.
REQ-026 Correct code in EXIT/ARMED/ENTRY/ALARM SHALL clear fail_cnt.
REQ-027 Wrong code in EXIT/ARMED/ENTRY/ALARM SHALL increment fail_cnt; when the increment reaches MAX_FAIL -> LOCKOUT (load LOCK_CYC-1), fail_cnt saturates at MAX_FAIL.
REQ-028 LOCKOUT: code_vld and zone_trip ignored; timer expiry -> ALARM with fail_cnt cleared to 0.
REQ-029 Priority per cycle: code evaluation > zone trip > timer expiry; a correct code in the same cycle as a trip or expiry SHALL disarm.
REQ-030 In DISARMED, arm_req and code_vld together: arm_req wins, code discarded.
REQ-031 Entering DISARMED SHALL clear trip_zone and fail_cnt.
REQ-032 All outputs SHALL be Moore, valid the cycle after the state register updates.

Reset
REQ-033 rst=1 at a clock edge SHALL force state=DISARMED, timer=0, siren=0, armed=0, trip_zone=0, fail_cnt=0, overriding all other inputs, including mid-ALARM or mid-LOCKOUT.

Verification
REQ-034 rst then arm_req, zones clear -> state=1 for 16 cycles, then state=2, armed=1, siren=0.
REQ-035 ARMED, zone_trip=4'b0001 -> ENTRY; no code for 8 cycles -> state=4, siren=1, trip_zone=0; code=4'hA -> state=0, siren=0.
REQ-036 ARMED, zone_trip=4'b0100 -> state=4 next cycle, trip_zone=2; zone_trip cleared -> siren stays 1.
REQ-037 ARMED, three codes 4'h3 -> fail_cnt 1,2, then state=5, siren=1; code 4'hA during lockout ignored; after 32 cycles state=4, fail_cnt=0.
REQ-038 ENTRY, code=4'hA and zone_trip=4'b1000 same cycle -> state=0, trip_zone=0.
REQ-039 ALARM, rst=1 for one cycle -> all outputs 0 next cycle; arm_req with zone_trip=4'b0010 -> remains state=0.

Source files
------------

// File: rtl/security_controller.sv
// Intrusion alarm controller: arm/exit/entry delays, keypad disarm with
// wrong-code lockout, and latching of the zone that triggered the alarm.
module security_controller #(
    parameter int         NZONES    = 4,
    parameter int         EXIT_CYC  = 16,
    parameter int         ENTRY_CYC = 8,
    parameter logic [3:0] CODE      = 4'hA,
    parameter int         MAX_FAIL  = 3,
    parameter int         LOCK_CYC  = 32,
    localparam int        ZW        = (NZONES > 1) ? $clog2(NZONES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NZONES-1:0] zone_trip,
    input  logic              arm_req,
    input  logic [3:0]        code,
    input  logic              code_vld,
    output logic              siren,
    output logic              armed,
    output logic [2:0]        state,
    output logic [ZW-1:0]     trip_zone,
    output logic [1:0]        fail_cnt
);
    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4,
        LOCKOUT  = 3'd5
    } state_e;

    localparam int TMAX0 = (EXIT_CYC > ENTRY_CYC) ? EXIT_CYC : ENTRY_CYC;
    localparam int TMAX  = (TMAX0 > LOCK_CYC) ? TMAX0 : LOCK_CYC;
    localparam int TW    = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0]     EXIT_LOAD  = TW'(EXIT_CYC - 1);
    localparam logic [TW-1:0]     ENTRY_LOAD = TW'(ENTRY_CYC - 1);
    localparam logic [TW-1:0]     LOCK_LOAD  = TW'(LOCK_CYC - 1);
    localparam logic [2:0]        MAXF3      = 3'(MAX_FAIL);
    localparam logic [1:0]        MAXF2      = 2'(MAX_FAIL);
    localparam logic [NZONES-1:0] Z0_MASK    = NZONES'(1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [ZW-1:0] trip_q, trip_d;
    logic [1:0]    fail_q, fail_d;
    logic          siren_q, armed_q;

    logic          code_ok, code_bad, expired, zone_hi, locked;
    logic [2:0]    fail_inc;
    logic [ZW-1:0] low_idx;

    assign code_ok  = code_vld && (code == CODE);
    assign code_bad = code_vld && (code != CODE);
    assign expired  = (timer_q == '0);
    assign zone_hi  = |(zone_trip & ~Z0_MASK);
    assign fail_inc = {1'b0, fail_q} + 3'd1;

    always_comb begin
        low_idx = '0;
        for (int i = NZONES - 1; i >= 0; i--) begin
            if (zone_trip[i]) low_idx = ZW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = expired ? '0 : timer_q - TW'(1);
        trip_d  = trip_q;
        fail_d  = fail_q;
        locked  = 1'b0;
        case (state_q)
            DISARMED: begin
                if (arm_req && (zone_trip == '0)) begin
                    state_d = EXIT;
                    timer_d = EXIT_LOAD;
                end
            end
            EXIT, ARMED, ENTRY, ALARM: begin
                // Code has priority; a wrong code only pre-empts trips/expiry when it locks out.
                if (code_ok) begin
                    state_d = DISARMED;
                    timer_d = '0;
                    trip_d  = '0;
                    fail_d  = '0;
                end else begin
                    if (code_bad) begin
                        if (fail_inc >= MAXF3) begin
                            state_d = LOCKOUT;
                            timer_d = LOCK_LOAD;
                            fail_d  = MAXF2;
                            locked  = 1'b1;
                        end else begin
                            fail_d = fail_inc[1:0];
                        end
                    end
                    if (!locked) begin
                        case (state_q)
                            EXIT: if (expired) state_d = ARMED;
                            ARMED: begin
                                if (zone_hi) begin
                                    state_d = ALARM;
                                    trip_d  = low_idx;
                                end else if (zone_trip[0]) begin
                                    state_d = ENTRY;
                                    timer_d = ENTRY_LOAD;
                                    trip_d  = '0;
                                end
                            end
                            ENTRY: if (zone_hi || expired) state_d = ALARM;
                            default: ;
                        endcase
                    end
                end
            end
            LOCKOUT: begin
                if (expired) begin
                    state_d = ALARM;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = DISARMED;
                timer_d = '0;
                trip_d  = '0;
                fail_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DISARMED;
            timer_q <= '0;
            trip_q  <= '0;
            fail_q  <= '0;
            siren_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            trip_q  <= trip_d;
            fail_q  <= fail_d;
            siren_q <= (state_d == ALARM) || (state_d == LOCKOUT);
            armed_q <= (state_d == ARMED) || (state_d == ENTRY);
        end
    end

    assign state     = state_q;
    assign siren     = siren_q;
    assign armed     = armed_q;
    assign trip_zone = trip_q;
    assign fail_cnt  = fail_q;
endmodule

// File: tb/tb_security_controller.sv
// Directed bench for security_controller with hand-computed expectations.
module tb_security_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] zone_trip;
    logic       arm_req;
    logic [3:0] code;
    logic       code_vld;
    logic       siren, armed;
    logic [2:0] state;
    logic [1:0] trip_zone;
    logic [1:0] fail_cnt;

    int errors = 0;
    int checks = 0;

    security_controller dut (
        .clk(clk), .rst(rst), .zone_trip(zone_trip), .arm_req(arm_req),
        .code(code), .code_vld(code_vld), .siren(siren), .armed(armed),
        .state(state), .trip_zone(trip_zone), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_code(input logic [3:0] c);
        code = c; code_vld = 1'b1;
        tick();
        code_vld = 1'b0;
    endtask

    // arm_req then 16 cycles of exit delay, landing in ARMED
    task automatic arm_fully();
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
        repeat (16) tick();
        check("armed_state", state, 2);
    endtask

    initial begin
        rst = 1'b1; zone_trip = '0; arm_req = 1'b0; code = '0; code_vld = 1'b0;
        #1;
        tick();
        rst = 1'b0;
        check("rst_state", state, 0);
        check("rst_siren", siren, 0);
        check("rst_armed", armed, 0);
        check("rst_trip", trip_zone, 0);
        check("rst_fail", fail_cnt, 0);

        // exit delay: 16 cycles in EXIT then ARMED
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
        check("exit_first", state, 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            if (state != 3'd1 || i == 15) check($sformatf("exit_cyc%0d", i), state, 1);
        end
        tick();
        check("exit_done_state", state, 2);
        check("exit_done_armed", armed, 1);
        check("exit_done_siren", siren, 0);

        // entry door, no code -> alarm after 8 cycles
        zone_trip = 4'b0001;
        tick();
        zone_trip = '0;
        check("entry_state", state, 3);
        check("entry_armed", armed, 1);
        repeat (7) tick();
        check("entry_last", state, 3);
        tick();
        check("entry_exp_state", state, 4);
        check("entry_exp_siren", siren, 1);
        check("entry_exp_trip", trip_zone, 0);
        check("entry_exp_armed", armed, 0);
        enter_code(4'hA);
        check("disarm_state", state, 0);
        check("disarm_siren", siren, 0);

        // interior zone -> immediate alarm, latched
        arm_fully();
        zone_trip = 4'b0100;
        tick();
        check("zone2_state", state, 4);
        check("zone2_trip", trip_zone, 2);
        zone_trip = '0;
        tick();
        check("zone2_hold_siren", siren, 1);
        check("zone2_hold_state", state, 4);
        enter_code(4'hA);
        check("zone2_disarm", state, 0);
        check("zone2_disarm_trip", trip_zone, 0);

        // wrong codes -> lockout, then alarm after 32 cycles
        arm_fully();
        enter_code(4'h3);
        check("fail1", fail_cnt, 1);
        check("fail1_state", state, 2);
        enter_code(4'h3);
        check("fail2", fail_cnt, 2);
        enter_code(4'h3);
        check("lock_state", state, 5);
        check("lock_siren", siren, 1);
        check("lock_fail", fail_cnt, 3);
        enter_code(4'hA);
        check("lock_ignore_code", state, 5);
        repeat (30) tick();
        check("lock_last", state, 5);
        tick();
        check("lock_exp_state", state, 4);
        check("lock_exp_fail", fail_cnt, 0);
        enter_code(4'hA);
        check("lock_disarm", state, 0);

        // correct code wins over simultaneous interior trip in ENTRY
        arm_fully();
        zone_trip = 4'b0001;
        tick();
        check("entry2_state", state, 3);
        zone_trip = 4'b1000; code = 4'hA; code_vld = 1'b1;
        tick();
        zone_trip = '0; code_vld = 1'b0;
        check("prio_state", state, 0);
        check("prio_trip", trip_zone, 0);

        // reset during alarm; arming blocked by a tripped zone
        arm_fully();
        zone_trip = 4'b0010;
        tick();
        zone_trip = '0;
        check("alarm_pre_rst", state, 4);
        check("alarm_pre_rst_trip", trip_zone, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_state", state, 0);
        check("mid_rst_siren", siren, 0);
        check("mid_rst_trip", trip_zone, 0);
        check("mid_rst_armed", armed, 0);
        arm_req = 1'b1; zone_trip = 4'b0010;
        tick();
        arm_req = 1'b0; zone_trip = '0;
        check("arm_blocked", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
